tx_arb: RTL and testbench

TX_ARB -- requirements
Module: tx_arb

---
 rtl/tx_arb_pkg.sv | 31 +++
 rtl/tx_arb_rr_pick.sv | 35 +++
 rtl/tx_arb.sv | 178 +++++++++++++++++
 tb/tb_tx_arb.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// -----------------------------------------------------------------------------
// tx_arb_pkg -- shared types and constants for the tx_arb transmit arbiter.
//   state_t        : arbiter FSM states
//   DATA_W         : width of one request word / transmitter word (32)
//   TMO_W          : width of the watchdog counter (8)
//   PTR_W          : width of the round-robin pointer (covers up to 8 requesters)
//   onehot_to_idx  : converts a one-hot vector (up to 8 bits) to its index
// -----------------------------------------------------------------------------
package tx_arb_pkg;

  localparam int DATA_W = 32;
  localparam int TMO_W  = 8;
  localparam int PTR_W  = 3;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_FIN = 2'd2,
    CLEAR    = 2'd3
  } state_t;

  function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [7:0] oh);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tx_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick -- combinational round-robin selector.
//   req   [N_REQ-1:0] : request vector
//   ptr   [PTR_W-1:0] : index where the search starts (wraps modulo N_REQ)
//   gnt   [N_REQ-1:0] : one-hot winner (all zero when nothing requests)
//   valid             : at least one request present
// -----------------------------------------------------------------------------
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic             valid
);

  always_comb begin
    int idx;
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      // First requester found walking upward from ptr wins.
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_arb.sv
// -----------------------------------------------------------------------------
// tx_arb -- round-robin arbiter feeding one serial transmitter.
// Optional feature: define TX_ARB_WATCHDOG_EN to enable the transfer watchdog
// (abort after TIMEOUT cycles in START/WAIT_FIN, flagged on err).
//   clk, rst_n   : clock, synchronous active-low reset
//   req          : per-requester level request, held until its done
//   req_data     : per-requester 32-bit word, slice i = [32i+31:32i]
//   gnt          : one-hot grant, high for the whole transaction
//   done         : one-cycle completion pulse to the granted requester
//   err          : one-cycle watchdog-abort pulse (0 without the watchdog)
//   tx_start     : start level to the transmitter
//   tx_data      : word presented to the transmitter
//   tx_busy_nxt  : one-cycle pulse clearing the transmitter's finish flag
//   tx_busy      : transmitter busy
//   tx_finish    : transmitter finish flag, sticky until tx_busy_nxt
// All outputs are registered.
// -----------------------------------------------------------------------------
module tx_arb
  import tx_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [DATA_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic                    tx_start,
  output logic [DATA_W-1:0]       tx_data,
  output logic                    tx_busy_nxt,
  input  logic                    tx_busy,
  input  logic                    tx_finish
);

  state_t              state_reg, state_next;
  logic [N_REQ-1:0]    gnt_reg, gnt_next;
  logic [N_REQ-1:0]    done_reg, done_next;
  logic                tx_start_reg, tx_start_next;
  logic [DATA_W-1:0]   tx_data_reg, tx_data_next;
  logic                busy_nxt_reg, busy_nxt_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [N_REQ-1:0]    pick_gnt;
  logic                pick_valid;
  logic [7:0]          pick_oh;
  logic [PTR_W-1:0]    pick_idx;
  logic                timeout;

  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req   (req),
    .ptr   (ptr_reg),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  always_comb begin
    pick_oh              = '0;
    pick_oh[N_REQ-1:0]   = pick_gnt;
    pick_idx             = onehot_to_idx(pick_oh);
  end

`ifdef TX_ARB_WATCHDOG_EN
  logic [TMO_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic             err_reg, err_next;

  // wd_cnt_reg counts cycles already spent in START/WAIT_FIN, so the abort
  // decision on count TIMEOUT-1 lands CLEAR exactly TIMEOUT cycles after START.
  assign timeout = (wd_cnt_reg == TMO_W'(TIMEOUT - 1));

  always_comb begin
    wd_cnt_next = '0;
    if (state_reg == START || state_reg == WAIT_FIN) wd_cnt_next = wd_cnt_reg + 1'b1;
    // A real finish arriving on the timeout cycle is a normal completion.
    err_next = timeout && ((state_reg == START) || (state_reg == WAIT_FIN && !tx_finish));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt_reg <= '0;
      err_reg    <= 1'b0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
      err_reg    <= err_next;
    end
  end

  assign err = err_reg;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      done_reg     <= '0;
      tx_start_reg <= 1'b0;
      tx_data_reg  <= '0;
      busy_nxt_reg <= 1'b0;
      ptr_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      gnt_reg      <= gnt_next;
      done_reg     <= done_next;
      tx_start_reg <= tx_start_next;
      tx_data_reg  <= tx_data_next;
      busy_nxt_reg <= busy_nxt_next;
      ptr_reg      <= ptr_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      // A stale finish flag must be cleared before a new transfer starts.
      IDLE:     if (!tx_finish && pick_valid) state_next = START;
      START:    if (timeout) state_next = CLEAR;
                else if (tx_busy) state_next = WAIT_FIN;
      WAIT_FIN: if (tx_finish || timeout) state_next = CLEAR;
      CLEAR:    state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs.
  always_comb begin
    gnt_next      = gnt_reg;
    done_next     = '0;
    tx_start_next = 1'b0;
    tx_data_next  = tx_data_reg;
    busy_nxt_next = 1'b0;
    ptr_next      = ptr_reg;
    case (state_reg)
      IDLE: begin
        gnt_next = '0;
        if (tx_finish) begin
          // Single pulse; the flag is still visible on the cycle the pulse is out.
          busy_nxt_next = !busy_nxt_reg;
        end else if (pick_valid) begin
          gnt_next      = pick_gnt;
          tx_start_next = 1'b1;
          tx_data_next  = req_data[DATA_W*int'(pick_idx) +: DATA_W];
          ptr_next      = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
      end
      START: begin
        if (timeout) begin
          gnt_next      = '0;
          done_next     = gnt_reg;
          busy_nxt_next = 1'b1;
        end else begin
          tx_start_next = !tx_busy;
        end
      end
      WAIT_FIN: begin
        if (tx_finish || timeout) begin
          gnt_next      = '0;
          done_next     = gnt_reg;
          busy_nxt_next = 1'b1;
        end
      end
      CLEAR:   gnt_next = '0;
      default: gnt_next = '0;
    endcase
  end

  assign gnt         = gnt_reg;
  assign done        = done_reg;
  assign tx_start    = tx_start_reg;
  assign tx_data     = tx_data_reg;
  assign tx_busy_nxt = busy_nxt_reg;

endmodule

// File: tb/tb_tx_arb.sv
// -----------------------------------------------------------------------------
// tb_tx_arb -- directed self-checking bench for tx_arb (N_REQ=4, TIMEOUT=16).
// The transmitter is played by the stimulus sequence itself (tx_busy and
// tx_finish are driven step by step). Watchdog checks are compiled when
// TX_ARB_WATCHDOG_EN is defined; otherwise the indefinite-wait behaviour is
// checked instead.
// -----------------------------------------------------------------------------
module tb_tx_arb;

  localparam int N = 4;
`ifdef TX_ARB_WATCHDOG_EN
  localparam int LONG_FIN = 12;
`else
  localparam int LONG_FIN = 70;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [32*N-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    done;
  logic            err;
  logic            tx_start;
  logic [31:0]     tx_data;
  logic            tx_busy_nxt;
  logic            tx_busy;
  logic            tx_finish;

  int tests = 0;
  int fails = 0;

  tx_arb #(.N_REQ(N), .TIMEOUT(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .done        (done),
    .err         (err),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy_nxt (tx_busy_nxt),
    .tx_busy     (tx_busy),
    .tx_finish   (tx_finish)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    case (i)
      0:       return 32'hA5A5_1234;
      1:       return 32'h1111_0001;
      2:       return 32'h2222_0002;
      default: return 32'h3333_0003;
    endcase
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},      32'(gnt), 32'h0);
    chk({tag, "_done"},     32'(done), 32'h0);
    chk({tag, "_err"},      32'(err), 32'h0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'h0);
    chk({tag, "_tx_data"},  tx_data, 32'h0);
    chk({tag, "_busy_nxt"}, 32'(tx_busy_nxt), 32'h0);
  endtask

  // One transfer: c counts cycles from the first cycle gnt is high (c=1).
  // Transmitter raises busy after cycle busy_at and finish after cycle fin_at.
  task automatic xfer(input string tag, input int idx, input logic [31:0] exp_data,
                      input int busy_at, input int fin_at, input int drop_at,
                      input bit chg_data);
    int c;
    int guard;
    logic [N-1:0] exp_gnt;
    exp_gnt = N'(1) << idx;
    guard = 0;
    while (gnt === '0 && guard < 20) begin
      step();
      guard++;
    end
    c = 1;
    chk({tag, "_gnt"},      32'(gnt), 32'(exp_gnt));
    chk({tag, "_tx_start"}, 32'(tx_start), 32'h1);
    chk({tag, "_tx_data"},  tx_data, exp_data);
    while (c <= fin_at) begin
      if (c == busy_at && c > 1) chk({tag, "_start_held"}, 32'(tx_start), 32'h1);
      if (c == busy_at + 1) begin
        chk({tag, "_start_drop"}, 32'(tx_start), 32'h0);
        chk({tag, "_gnt_hold"},   32'(gnt), 32'(exp_gnt));
        chk({tag, "_data_hold"},  tx_data, exp_data);
      end
      if (chg_data && c == 1) req_data[31:0] = 32'hFFFF_FFFF;
      if (c == drop_at) req = '0;
      if (c == busy_at) tx_busy = 1'b1;
      if (c == fin_at) begin
        tx_busy   = 1'b0;
        tx_finish = 1'b1;
      end
      step();
      c++;
    end
    // CLEAR cycle
    chk({tag, "_done"},       32'(done), 32'(exp_gnt));
    chk({tag, "_clr_busynx"}, 32'(tx_busy_nxt), 32'h1);
    chk({tag, "_clr_gnt"},    32'(gnt), 32'h0);
    chk({tag, "_clr_data"},   tx_data, exp_data);
    chk({tag, "_clr_start"},  32'(tx_start), 32'h0);
    chk({tag, "_clr_err"},    32'(err), 32'h0);
    $display("[TB] %s: requester %0d data %0h done", tag, idx, exp_data);
    tx_finish = 1'b0;
    if (drop_at > fin_at) req = '0;
    step();
    // IDLE cycle
    chk({tag, "_idle_done"},   32'(done), 32'h0);
    chk({tag, "_idle_busynx"}, 32'(tx_busy_nxt), 32'h0);
    chk({tag, "_idle_start"},  32'(tx_start), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req       = '0;
    tx_busy   = 1'b0;
    tx_finish = 1'b0;
    for (int i = 0; i < N; i++) req_data[32*i +: 32] = word(i);
    step();
    step();
    chk_all_zero("reset");

    // Single transfer, with data change after grant (must be ignored).
    rst_n = 1'b1;
    req   = 4'b0001;
    step();
    xfer("single", 0, 32'hA5A5_1234, 3, LONG_FIN, LONG_FIN + 1, 1'b1);

    // Requester drops its request mid-transaction; transfer still completes.
    req = 4'b0100;
    step();
    xfer("req_drop", 2, word(2), 3, 6, 2, 1'b0);

    // Fairness from a fresh pointer: order 0,1,2,3,0,1,2,3.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("fair_rst_gnt", 32'(gnt), 32'h0);
    req_data[31:0] = word(0);
    req = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      xfer("fair", i % 4, word(i % 4), 2, 5, (i == 7) ? 6 : 0, 1'b0);
    end

    // Reset during WAIT_FIN, then requesters 3 and 0 -> 0 wins.
    req = 4'b1000;
    step();
    chk("rstmid_gnt3", 32'(gnt), 32'h8);
    tx_busy = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk_all_zero("rstmid");
    rst_n   = 1'b1;
    tx_busy = 1'b0;
    req     = 4'b1001;
    step();
    xfer("rstmid_regrant", 0, word(0), 2, 5, 6, 1'b0);

    // Stale finish at reset release: clear pulse first, then grant.
    rst_n     = 1'b0;
    tx_finish = 1'b1;
    req       = '0;
    step();
    rst_n = 1'b1;
    req   = 4'b0010;
    step();
    chk("stale_busynx", 32'(tx_busy_nxt), 32'h1);
    chk("stale_gnt0",   32'(gnt), 32'h0);
    step();
    chk("stale_busynx_end", 32'(tx_busy_nxt), 32'h0);
    chk("stale_gnt1",       32'(gnt), 32'h0);
    tx_finish = 1'b0;
    xfer("stale", 1, word(1), 2, 5, 6, 1'b0);

    // Transmitter never responds.
    req = 4'b0001;
    step();
    chk("hang_gnt", 32'(gnt), 32'h1);
`ifdef TX_ARB_WATCHDOG_EN
    repeat (15) step();
    chk("wd_pre_done", 32'(done), 32'h0);
    chk("wd_pre_err",  32'(err), 32'h0);
    chk("wd_pre_gnt",  32'(gnt), 32'h1);
    step();
    chk("wd_done",   32'(done), 32'h1);
    chk("wd_err",    32'(err), 32'h1);
    chk("wd_busynx", 32'(tx_busy_nxt), 32'h1);
    chk("wd_gnt",    32'(gnt), 32'h0);
    chk("wd_start",  32'(tx_start), 32'h0);
    $display("[TB] watchdog: requester 0 aborted");
    req = '0;
    step();
    chk("wd_err_end",  32'(err), 32'h0);
    chk("wd_done_end", 32'(done), 32'h0);
    req = 4'b0010;
    step();
    xfer("wd_after", 1, word(1), 2, 5, 6, 1'b0);
`else
    repeat (40) step();
    chk("nowd_gnt",   32'(gnt), 32'h1);
    chk("nowd_done",  32'(done), 32'h0);
    chk("nowd_err",   32'(err), 32'h0);
    chk("nowd_start", 32'(tx_start), 32'h1);
    $display("[TB] no watchdog: requester 0 still waiting after 40 cycles");
    xfer("nowd_finish", 0, word(0), 2, 5, 6, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
